// File: rtl/a51_keystream_core.sv
// A5/1 keystream engine: loads key and frame, runs the discard phase, then streams
// majority-clocked keystream as MSB-first 32-bit words over a valid/ready handshake.
module a51_keystream_core #(
    parameter int DISCARD_CYCLES = 100,
    parameter int KS_BITS        = 228
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [63:0] key_i,
    input  logic [21:0] frame_i,
    output logic        busy_o,
    output logic        ks_valid_o,
    input  logic        ks_ready_i,
    output logic [31:0] ks_data_o,
    output logic        ks_last_o
);

    localparam int DATA_W     = 32;
    localparam int BIT_W      = ($clog2(KS_BITS + 1) > 6) ? $clog2(KS_BITS + 1) : 6;
    localparam int LAST_SHIFT = (KS_BITS % DATA_W == 0) ? 0 : DATA_W - (KS_BITS % DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(KS_BITS);
    localparam logic [6:0]       MIX_LAST = 7'(DISCARD_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_FRAME, S_MIX, S_GEN, S_DRAIN} state_t;

    state_t             state;
    logic [18:0]        r1;
    logic [21:0]        r2;
    logic [22:0]        r3;
    logic [63:0]        key_q;
    logic [21:0]        frame_q;
    logic [6:0]         phase_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  acc;

    function automatic logic [18:0] clk_r1(input logic [18:0] r);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18]};
    endfunction

    function automatic logic [21:0] clk_r2(input logic [21:0] r);
        return {r[20:0], r[20] ^ r[21]};
    endfunction

    function automatic logic [22:0] clk_r3(input logic [22:0] r);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22]};
    endfunction

    logic              maj;
    logic [18:0]       r1_mj;
    logic [21:0]       r2_mj;
    logic [22:0]       r3_mj;
    logic              ks_bit;
    logic [BIT_W-1:0]  bit_cnt_nx;
    logic [DATA_W-1:0] acc_nx;
    logic              final_bit;
    logic              word_done;
    logic              slot_free;
    logic              gen_adv;

    // Majority step and the candidate keystream bit, shared by MIX and GEN
    always_comb begin
        maj        = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        r1_mj      = (r1[8]  == maj) ? clk_r1(r1) : r1;
        r2_mj      = (r2[10] == maj) ? clk_r2(r2) : r2;
        r3_mj      = (r3[10] == maj) ? clk_r3(r3) : r3;
        ks_bit     = r1_mj[18] ^ r2_mj[21] ^ r3_mj[22];
        bit_cnt_nx = bit_cnt + 1'b1;
        acc_nx     = {acc[DATA_W-2:0], ks_bit};
        final_bit  = (bit_cnt_nx == BIT_LAST);
        word_done  = (bit_cnt_nx[4:0] == 5'd0) || final_bit;
        slot_free  = !ks_valid_o || ks_ready_i;
        // A word-completing bit is only produced when it can go straight to the output slot
        gen_adv    = (state == S_GEN) && (!word_done || slot_free);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            r1         <= '0;
            r2         <= '0;
            r3         <= '0;
            key_q      <= '0;
            frame_q    <= '0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            busy_o     <= 1'b0;
            ks_valid_o <= 1'b0;
            ks_data_o  <= '0;
            ks_last_o  <= 1'b0;
        end else begin
            if (ks_valid_o && ks_ready_i) begin
                ks_valid_o <= 1'b0;
                ks_last_o  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        frame_q   <= frame_i;
                        r1        <= '0;
                        r2        <= '0;
                        r3        <= '0;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        acc       <= '0;
                        busy_o    <= 1'b1;
                        state     <= S_KEY;
                    end
                end
                S_KEY: begin
                    r1    <= clk_r1(r1) ^ {18'd0, key_q[0]};
                    r2    <= clk_r2(r2) ^ {21'd0, key_q[0]};
                    r3    <= clk_r3(r3) ^ {22'd0, key_q[0]};
                    key_q <= key_q >> 1;
                    if (phase_cnt == 7'd63) begin
                        phase_cnt <= '0;
                        state     <= S_FRAME;
                    end else begin
                        phase_cnt <= phase_cnt + 7'd1;
                    end
                end
                S_FRAME: begin
                    r1      <= clk_r1(r1) ^ {18'd0, frame_q[0]};
                    r2      <= clk_r2(r2) ^ {21'd0, frame_q[0]};
                    r3      <= clk_r3(r3) ^ {22'd0, frame_q[0]};
                    frame_q <= frame_q >> 1;
                    if (phase_cnt == 7'd21) begin
                        phase_cnt <= '0;
                        state     <= S_MIX;
                    end else begin
                        phase_cnt <= phase_cnt + 7'd1;
                    end
                end
                S_MIX: begin
                    r1 <= r1_mj;
                    r2 <= r2_mj;
                    r3 <= r3_mj;
                    if (phase_cnt == MIX_LAST) begin
                        phase_cnt <= '0;
                        state     <= S_GEN;
                    end else begin
                        phase_cnt <= phase_cnt + 7'd1;
                    end
                end
                S_GEN: begin
                    if (gen_adv) begin
                        r1      <= r1_mj;
                        r2      <= r2_mj;
                        r3      <= r3_mj;
                        bit_cnt <= bit_cnt_nx;
                        if (word_done) begin
                            acc        <= '0;
                            ks_valid_o <= 1'b1;
                            ks_data_o  <= final_bit ? (acc_nx << LAST_SHIFT) : acc_nx;
                            ks_last_o  <= final_bit;
                            if (final_bit) state <= S_DRAIN;
                        end else begin
                            acc <= acc_nx;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ks_valid_o && ks_ready_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a51_keystream_core.sv
// Scoreboard bench for a51_keystream_core: expected words are queued at stimulus time
// and popped by monitors on every valid/ready handshake.
module tb_a51_keystream_core;

    localparam logic [63:0] KEY_A   = 64'hEFCDAB8967452312;
    localparam logic [21:0] FRAME_A = 22'h134;
    localparam logic [22:0] T1 = 23'h072000;
    localparam logic [22:0] T2 = 23'h300000;
    localparam logic [22:0] T3 = 23'h700080;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        busy, ks_valid, ks_last;
    logic        ks_ready = 1'b1;
    logic [31:0] ks_data;

    logic        start2 = 1'b0;
    logic        busy2, valid2, last2;
    logic        ready2 = 1'b1;
    logic [31:0] data2;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_hs = 0;

    always #5 clk = ~clk;

    a51_keystream_core dut (
        .clk(clk), .reset_n(reset_n), .start_i(start), .key_i(key), .frame_i(frame),
        .busy_o(busy), .ks_valid_o(ks_valid), .ks_ready_i(ks_ready),
        .ks_data_o(ks_data), .ks_last_o(ks_last)
    );

    a51_keystream_core #(.DISCARD_CYCLES(1), .KS_BITS(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .start_i(start2), .key_i(key), .frame_i(frame),
        .busy_o(busy2), .ks_valid_o(valid2), .ks_ready_i(ready2),
        .ks_data_o(data2), .ks_last_o(last2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [22:0] lfsr_step(input logic [22:0] r, input logic [22:0] taps,
                                              input int len);
        logic fb;
        fb = ^(r & taps);
        return ((r << 1) | {22'd0, fb}) & (23'h7fffff >> (23 - len));
    endfunction

    task automatic maj_clock(inout logic [22:0] a, inout logic [22:0] b, inout logic [22:0] c);
        logic m;
        m = (int'(a[8]) + int'(b[10]) + int'(c[10])) > 1;
        if (a[8] == m)  a = lfsr_step(a, T1, 19);
        if (b[10] == m) b = lfsr_step(b, T2, 22);
        if (c[10] == m) c = lfsr_step(c, T3, 23);
    endtask

    // Reference A5/1 run; queues words from first_word onward
    task automatic model_push(input logic [63:0] k, input logic [21:0] f, input int discard,
                              input int nbits, input int first_word, input bit sel2);
        logic [22:0] a, b, c;
        logic [31:0] w;
        exp_t        e;
        a = '0; b = '0; c = '0; w = '0;
        for (int i = 0; i < 64; i++) begin
            a = lfsr_step(a, T1, 19); b = lfsr_step(b, T2, 22); c = lfsr_step(c, T3, 23);
            a[0] ^= k[i]; b[0] ^= k[i]; c[0] ^= k[i];
        end
        for (int i = 0; i < 22; i++) begin
            a = lfsr_step(a, T1, 19); b = lfsr_step(b, T2, 22); c = lfsr_step(c, T3, 23);
            a[0] ^= f[i]; b[0] ^= f[i]; c[0] ^= f[i];
        end
        for (int i = 0; i < discard; i++) maj_clock(a, b, c);
        for (int i = 0; i < nbits; i++) begin
            maj_clock(a, b, c);
            w[31 - (i % 32)] = a[18] ^ b[21] ^ c[22];
            if ((i % 32 == 31) || (i == nbits - 1)) begin
                if (i / 32 >= first_word) begin
                    e.d = w;
                    e.l = (i == nbits - 1);
                    if (sel2) exp2_q.push_back(e);
                    else      exp_q.push_back(e);
                end
                w = '0;
            end
        end
    endtask

    task automatic push_const(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic push_key_vector();
        push_const(32'h534EAA58, 1'b0);
        push_const(32'h2FE8151A, 1'b0);
        push_const(32'hB6E1855A, 1'b0);
        model_push(KEY_A, FRAME_A, 100, 228, 3, 1'b0);
    endtask

    task automatic start_run(input logic [63:0] k, input logic [21:0] f);
        @(negedge clk);
        key = k;
        frame = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on_accept", busy, 1'b1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!ks_valid && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!ks_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: timeout, got no valid, expected valid");
        end
    endtask

    task automatic wait_idle(input bit rand_ready, output int cyc);
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
            if (rand_ready) ks_ready = 1'($urandom_range(0, 1));
        end
        ks_ready = 1'b1;
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic end_of_run(input int base);
        check("queue_empty", exp_q.size(), 0);
        check("word_count", n_hs - base, 8);
    endtask

    // Main-DUT monitor: scoreboard pop on handshake, hold stability under backpressure
    initial begin : monitor
        logic        held;
        logic [31:0] held_d;
        logic        held_l;
        exp_t        e;
        held = 1'b0; held_d = '0; held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", ks_valid, 1'b1);
                    check("hold_data", ks_data, held_d);
                    check("hold_last", ks_last, held_l);
                end
                if (ks_valid && ks_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_word: got %h, expected none", ks_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", ks_data, e.d);
                        check("last_flag", ks_last, e.l);
                    end
                    n_hs++;
                end
                held = ks_valid && !ks_ready;
                held_d = ks_data;
                held_l = ks_last;
            end
        end
    end

    initial begin : monitor2
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && valid2 && ready2) begin
                if (exp2_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_word2: got %h, expected none", data2);
                end else begin
                    e = exp2_q.pop_front();
                    check("word2", data2, e.d);
                    check("last_flag2", last2, e.l);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, idle_cyc, base, guard;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", ks_valid, 1'b0);
        check("rst_data", ks_data, 32'h0);
        check("rst_last", ks_last, 1'b0);
        @(negedge clk) reset_n = 1'b1;

        // Reference key vector with continuous ready
        base = n_hs;
        push_key_vector();
        start_run(KEY_A, FRAME_A);
        wait_valid(lat);
        check("first_valid_latency", lat, 218);
        wait_idle(1'b0, idle_cyc);
        check("run_length", lat + idle_cyc, 415);
        end_of_run(base);

        // All-zero key and frame
        base = n_hs;
        for (int i = 0; i < 8; i++) push_const(32'h0, i == 7);
        start_run(64'h0, 22'h0);
        wait_valid(lat);
        wait_idle(1'b0, idle_cyc);
        check("zero_run_length", lat + idle_cyc, 415);
        end_of_run(base);

        // Backpressure: hold word0, then release into random ready
        base = n_hs;
        push_key_vector();
        ks_ready = 1'b0;
        start_run(KEY_A, FRAME_A);
        wait_valid(lat);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check("word0_still_held", ks_data, 32'h534EAA58);
        ks_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_back_to_back", ks_valid, 1'b1);
        wait_idle(1'b1, idle_cyc);
        end_of_run(base);

        // Start pulse with another key during MIX is ignored
        base = n_hs;
        push_key_vector();
        start_run(KEY_A, FRAME_A);
        repeat (120) @(posedge clk);
        @(negedge clk);
        key = 64'h0123456789ABCDEF;
        frame = 22'h3FFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(1'b0, idle_cyc);
        end_of_run(base);

        // Reset after word2 handshake, then restart
        base = n_hs;
        push_key_vector();
        start_run(KEY_A, FRAME_A);
        guard = 0;
        while (n_hs < base + 3 && guard < 2000) begin
            @(negedge clk);
            #2 guard++;
        end
        check("reached_word2", n_hs - base, 3);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", ks_valid, 1'b0);
        check("midrst_data", ks_data, 32'h0);
        check("midrst_last", ks_last, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_partial_after_rst", ks_valid, 1'b0);
        base = n_hs;
        push_const(32'h534EAA58, 1'b0);
        model_push(KEY_A, FRAME_A, 100, 228, 1, 1'b0);
        start_run(KEY_A, FRAME_A);
        wait_idle(1'b0, idle_cyc);
        end_of_run(base);

        // Short configuration: one discard cycle, one 32-bit word
        model_push(KEY_A, FRAME_A, 1, 32, 0, 1'b1);
        @(negedge clk);
        key = KEY_A;
        frame = FRAME_A;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lat = 0;
        while (!valid2 && lat < 500) begin
            @(posedge clk);
            #1 lat++;
        end
        check("short_latency", lat, 119);
        check("short_last", last2, 1'b1);
        guard = 0;
        while (busy2 && guard < 100) begin
            @(posedge clk);
            #1 guard++;
        end
        check("short_idle", busy2, 1'b0);
        check("short_queue_empty", exp2_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
